mdu_sequencer: RTL and testbench

// Sequences the E-stage multiply/divide unit and owns the HI/LO registers.

---
 rtl/mdu_sequencer_pkg.sv | 22 ++
 rtl/mdu_sequencer_calc.sv | 43 ++++
 rtl/mdu_sequencer.sv | 84 ++++++++
 tb/tb_mdu_sequencer.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/mdu_sequencer_pkg.sv
// Shared MDU operation codes and helpers for the E-stage multiply/divide sequencer.
package mdu_sequencer_pkg;

  localparam logic [3:0] MDUop_null  = 4'd0;
  localparam logic [3:0] MDUop_mult  = 4'd1;
  localparam logic [3:0] MDUop_multu = 4'd2;
  localparam logic [3:0] MDUop_div   = 4'd3;
  localparam logic [3:0] MDUop_divu  = 4'd4;
  localparam logic [3:0] MDUop_mfhi  = 4'd5;
  localparam logic [3:0] MDUop_mflo  = 4'd6;
  localparam logic [3:0] MDUop_mthi  = 4'd7;
  localparam logic [3:0] MDUop_mtlo  = 4'd8;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == MDUop_div) || (op == MDUop_divu);
  endfunction

endpackage

// File: rtl/mdu_sequencer_calc.sv
// Combinational multiply/divide datapath; divides by zero report div0 and yield 0.
module mdu_calc
  import mdu_sequencer_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_hi_res,
  output logic [31:0] o_lo_res,
  output logic        o_div0
);

  logic signed [63:0] w_sprod;
  logic        [63:0] w_uprod;
  logic signed [31:0] w_sq, w_sr;
  logic        [31:0] w_uq, w_ur;
  logic               w_bz;

  assign w_bz    = (i_b == 32'd0);
  assign w_sprod = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
  assign w_uprod = {32'd0, i_a} * {32'd0, i_b};

  // Guard the divider so a zero divisor never propagates X.
  assign w_sq = w_bz ? 32'sd0 : $signed(i_a) / $signed(i_b);
  assign w_sr = w_bz ? 32'sd0 : $signed(i_a) % $signed(i_b);
  assign w_uq = w_bz ? 32'd0  : i_a / i_b;
  assign w_ur = w_bz ? 32'd0  : i_a % i_b;

  assign o_div0 = is_div(i_op) && w_bz;

  always_comb begin
    o_hi_res = 32'd0;
    o_lo_res = 32'd0;
    case (i_op)
      MDUop_mult:  {o_hi_res, o_lo_res} = w_sprod;
      MDUop_multu: {o_hi_res, o_lo_res} = w_uprod;
      MDUop_div:   begin o_hi_res = w_sr; o_lo_res = w_sq; end
      MDUop_divu:  begin o_hi_res = w_ur; o_lo_res = w_uq; end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_sequencer.sv
// E-stage MDU sequencer: fixed-latency busy countdown, HI/LO ownership, mf/mt service.
module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUop,
  input  logic        Start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Req,
  output logic        Busy,
  output logic [31:0] MDUout
);

  localparam int CW = $clog2(imax(MULT_CYCLES, DIV_CYCLES)) + 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_hi, r_lo, r_phi, r_plo;
  logic          r_pdiv0;

  logic [31:0]   w_hi_res, w_lo_res;
  logic          w_div0;

  mdu_calc u_calc (
    .i_op     (MDUop),
    .i_a      (A),
    .i_b      (B),
    .o_hi_res (w_hi_res),
    .o_lo_res (w_lo_res),
    .o_div0   (w_div0)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_phi   <= '0;
      r_plo   <= '0;
      r_pdiv0 <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (!Req) begin
          if (Start) begin
            r_phi   <= w_hi_res;
            r_plo   <= w_lo_res;
            r_pdiv0 <= w_div0;
            r_cnt   <= is_div(MDUop) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            r_state <= RUN;
          end else if (MDUop == MDUop_mthi) begin
            r_hi <= A;
          end else if (MDUop == MDUop_mtlo) begin
            r_lo <= A;
          end
        end
        // Req cannot cancel here: the running op belongs to an already-committed instruction.
        RUN: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            if (!r_pdiv0) begin
              r_hi <= r_phi;
              r_lo <= r_plo;
            end
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Busy   = (r_state == RUN);
  assign MDUout = (MDUop == MDUop_mfhi) ? r_hi :
                  (MDUop == MDUop_mflo) ? r_lo : 32'd0;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed-vector bench for mdu_sequencer with hand-computed HI/LO and busy lengths.
module tb_mdu_sequencer;
  import mdu_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  MDUop = MDUop_null;
  logic        Start = 1'b0;
  logic [31:0] A = '0, B = '0;
  logic        Req = 1'b0;
  logic        Busy;
  logic [31:0] MDUout;

  int n_cmp = 0;
  int n_err = 0;

  mdu_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .MDUop(MDUop), .Start(Start),
    .A(A), .B(B), .Req(Req), .Busy(Busy), .MDUout(MDUout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    MDUop = MDUop_null; Start = 1'b0; Req = 1'b0; A = '0; B = '0;
  endtask

  task automatic rd_hilo(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
    MDUop = MDUop_mfhi; #1;
    chk({tag, "_hi"}, MDUout, ehi);
    MDUop = MDUop_mflo; #1;
    chk({tag, "_lo"}, MDUout, elo);
    MDUop = MDUop_null; #1;
  endtask

  // Launch an op, then count cycles with Busy high (bounded).
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_busy);
    int cnt;
    MDUop = op; Start = 1'b1; A = a; B = b;
    step();
    idle_in();
    cnt = 0;
    while (Busy && cnt < 40) begin
      cnt++;
      step();
    end
    chk({tag, "_busy"}, 32'(cnt), 32'(exp_busy));
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] a, input logic req);
    MDUop = op; A = a; Req = req;
    step();
    idle_in();
  endtask

  initial begin
    step(); step();
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    rd_hilo("rst", 32'd0, 32'd0);
    reset = 1'b0;
    step();

    run_op("mult", MDUop_mult, 32'd3, 32'hFFFF_FFFE, 5);
    rd_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    run_op("multu", MDUop_multu, 32'hFFFF_FFFF, 32'd2, 5);
    rd_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);

    run_op("divu", MDUop_divu, 32'd7, 32'd2, 10);
    rd_hilo("divu", 32'd1, 32'd3);

    run_op("div", MDUop_div, 32'hFFFF_FFF9, 32'd2, 10);
    rd_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    mt(MDUop_mthi, 32'h11, 1'b0);
    mt(MDUop_mtlo, 32'h22, 1'b0);
    rd_hilo("mt", 32'h11, 32'h22);
    run_op("div0", MDUop_div, 32'd5, 32'd0, 10);
    rd_hilo("div0", 32'h11, 32'h22);

    // Start with flush: no launch.
    MDUop = MDUop_mult; Start = 1'b1; A = 32'd3; B = 32'd4; Req = 1'b1;
    step();
    idle_in();
    chk("req_start_busy", {31'd0, Busy}, 32'd0);
    step(); step(); step(); step(); step(); step();
    rd_hilo("req_start", 32'h11, 32'h22);
    mt(MDUop_mthi, 32'h99, 1'b1);
    mt(MDUop_mtlo, 32'h98, 1'b1);
    rd_hilo("req_mt", 32'h11, 32'h22);

    // Req during RUN must not cancel the running op.
    MDUop = MDUop_multu; Start = 1'b1; A = 32'd6; B = 32'd7;
    step();
    idle_in();
    Req = 1'b1; step(); Req = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("req_run_busy", {31'd0, Busy}, 32'd0);
    rd_hilo("req_run", 32'd0, 32'd42);

    // mthi while running is ignored.
    MDUop = MDUop_mult; Start = 1'b1; A = 32'd2; B = 32'd5;
    step();
    idle_in();
    mt(MDUop_mthi, 32'h55, 1'b0);
    for (int i = 0; i < 6; i++) step();
    rd_hilo("mt_run", 32'd0, 32'd10);

    // Reset in the 3rd busy cycle of a div.
    MDUop = MDUop_div; Start = 1'b1; A = 32'd100; B = 32'd7;
    step();
    idle_in();
    step(); step();
    chk("mid_busy_pre", {31'd0, Busy}, 32'd1);
    reset = 1'b1; #1;
    chk("mid_busy", {31'd0, Busy}, 32'd0);
    rd_hilo("mid_rst", 32'd0, 32'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) step();
    chk("mid_busy_post", {31'd0, Busy}, 32'd0);
    rd_hilo("mid_post", 32'd0, 32'd0);

    mt(MDUop_mthi, 32'hDEAD_BEEF, 1'b0);
    MDUop = MDUop_mfhi; #1;
    chk("mfhi_fwd", MDUout, 32'hDEAD_BEEF);
    mt(MDUop_mtlo, 32'h1234_5678, 1'b0);
    MDUop = MDUop_mflo; #1;
    chk("mflo", MDUout, 32'h1234_5678);
    MDUop = MDUop_null; #1;
    chk("null_out", MDUout, 32'd0);
    MDUop = 4'hF; #1;
    chk("unk_out", MDUout, 32'd0);
    step();
    idle_in(); #1;
    rd_hilo("unk_keep", 32'hDEAD_BEEF, 32'h1234_5678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
